// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file: FSM states,
// depth calculation and packed-bus lane extraction.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Widest packed bus lane_sel can slice; callers zero-extend into this width.
  localparam int unsigned LANE_BUS_W = 256;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic logic [LANE_BUS_W-1:0] lane_sel(
    input logic [LANE_BUS_W-1:0] bus,
    input int unsigned           idx,
    input int unsigned           w
  );
    logic [LANE_BUS_W-1:0] mask;
    mask = (w >= LANE_BUS_W) ? '1 : ((LANE_BUS_W'(1) << w) - LANE_BUS_W'(1));
    return (bus >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/regfile_read_lane.sv
// One combinational read port: gates on ready, applies the hardwired-zero
// register and optional same-cycle write forwarding, else returns storage.
module regfile_read_lane #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              ready_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic zero_hit;
  logic bypass_hit;

  assign zero_hit   = (ZERO_REG != 0) && (rd_addr_i == '0);
  assign bypass_hit = (BYPASS != 0) && wr_en_i && (rd_addr_i == wr_addr_i);

  always_comb begin
    rd_data_o = mem_rdata_i;
    if (!ready_i) begin
      rd_data_o = '0;
    end else if (zero_hit) begin
      rd_data_o = '0;
    end else if (bypass_hit) begin
      rd_data_o = wr_data_i;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-read-port register file with a post-reset clear sweep
// that zeroes one entry per cycle before raising ready.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     RegWrite,
  output logic                     ready,
  output logic                     clr_busy
);

  localparam int DEPTH = int'(depth_of(ADDR_W));

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_idx_q;
  logic                ready_q;
  logic                clr_busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_waddr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic [LANE_BUS_W-1:0] rd_bus_pad;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      ready_q    <= 1'b0;
      clr_busy_q <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          // Index wraps to 0 naturally after the last entry.
          clr_idx_q <= clr_idx_q + ADDR_W'(1);
          if (clr_idx_q == '1) begin
            state_q    <= ST_RUN;
            ready_q    <= 1'b1;
            clr_busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          ready_q    <= 1'b1;
          clr_busy_q <= 1'b0;
        end
        default: begin
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

  // Single write port shared by the sweep and normal writes; sweep wins.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = write_reg;
    mem_wdata_d = write_data;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = clr_idx_q;
        mem_wdata_d = '0;
      end else if (RegWrite && !((ZERO_REG != 0) && (write_reg == '0))) begin
        mem_we_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  assign ready      = ready_q;
  assign clr_busy   = clr_busy_q;
  assign rd_bus_pad = LANE_BUS_W'(read_reg);

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_lane
      logic [ADDR_W-1:0] rd_addr;
      logic [DATA_W-1:0] rd_data;

      assign rd_addr = ADDR_W'(lane_sel(rd_bus_pad, gi, ADDR_W));

      regfile_read_lane #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
      ) u_lane (
        .ready_i    (ready_q),
        .rd_addr_i  (rd_addr),
        .mem_rdata_i(mem_q[rd_addr]),
        .wr_en_i    (RegWrite),
        .wr_addr_i  (write_reg),
        .wr_data_i  (write_data),
        .rd_data_o  (rd_data)
      );

      assign read_data[gi*DATA_W +: DATA_W] = rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench: two register files (default build, and a 16-bit/16-deep/
// 3-port build without zero register or bypass) checked against array models.
module tb_regfile_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DATA_W=32, ADDR_W=3, NUM_RD=2, ZERO_REG=1, BYPASS=1
  logic        a_rst, a_we, a_ready, a_busy;
  logic [5:0]  a_rreg;
  logic [63:0] a_rdata;
  logic [2:0]  a_wreg;
  logic [31:0] a_wdata;

  // Instance B: DATA_W=16, ADDR_W=4, NUM_RD=3, ZERO_REG=0, BYPASS=0
  logic        b_rst, b_we, b_ready, b_busy;
  logic [11:0] b_rreg;
  logic [47:0] b_rdata;
  logic [3:0]  b_wreg;
  logic [15:0] b_wdata;

  regfile_multiport #(
    .DATA_W(32), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clock(clk), .reset(a_rst), .read_reg(a_rreg), .read_data(a_rdata),
    .write_reg(a_wreg), .write_data(a_wdata), .RegWrite(a_we),
    .ready(a_ready), .clr_busy(a_busy)
  );

  regfile_multiport #(
    .DATA_W(16), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)
  ) dut_b (
    .clock(clk), .reset(b_rst), .read_reg(b_rreg), .read_data(b_rdata),
    .write_reg(b_wreg), .write_data(b_wdata), .RegWrite(b_we),
    .ready(b_ready), .clr_busy(b_busy)
  );

  typedef struct {
    int          inst;
    bit          rdy;
    logic [63:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;

  // Reference state: storage contents and cycles of sweep completed since reset.
  logic [31:0] ma [8];
  logic [15:0] mb [16];
  int          ca, cb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    int   ad;
    e.inst = 0;
    e.rdy  = (ca == 8);
    e.data = '0;
    for (int i = 0; i < 2; i++) begin
      ad = int'(a_rreg[i*3 +: 3]);
      if (!e.rdy || ad == 0)                  e.data[i*32 +: 32] = 32'h0;
      else if (a_we && ad == int'(a_wreg))    e.data[i*32 +: 32] = a_wdata;
      else                                    e.data[i*32 +: 32] = ma[ad];
    end
    sb_q.push_back(e);

    e.inst = 1;
    e.rdy  = (cb == 16);
    e.data = '0;
    for (int i = 0; i < 3; i++) begin
      ad = int'(b_rreg[i*4 +: 4]);
      e.data[i*16 +: 16] = e.rdy ? mb[ad] : 16'h0;
    end
    sb_q.push_back(e);
  endtask

  task automatic commit();
    if (a_rst) ca = 0;
    else if (ca < 8) begin
      ca++;
      if (ca == 8) for (int k = 0; k < 8; k++) ma[k] = 32'h0;
    end else if (a_we && a_wreg != 3'd0) ma[a_wreg] = a_wdata;

    if (b_rst) cb = 0;
    else if (cb < 16) begin
      cb++;
      if (cb == 16) for (int k = 0; k < 16; k++) mb[k] = 16'h0;
    end else if (b_we) mb[b_wreg] = b_wdata;
  endtask

  task automatic cycle();
    push_expected();
    $display("[TB] cyc %0d A rst=%0d we=%0d w%0d=%h r=%h | B rst=%0d we=%0d w%0d=%h r=%h",
             cyc, a_rst, a_we, a_wreg, a_wdata, a_rreg, b_rst, b_we, b_wreg, b_wdata, b_rreg);
    @(posedge clk);
    commit();
    cyc++;
    #1;
  endtask

  // Monitor: every negedge the DUT outputs are valid; compare against queued expectations.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.inst == 0) begin
        check("a_ready", 64'(a_ready), 64'(e.rdy));
        check("a_clr_busy", 64'(a_busy), 64'(!e.rdy));
        check("a_read_data", a_rdata, e.data);
      end else begin
        check("b_ready", 64'(b_ready), 64'(e.rdy));
        check("b_clr_busy", 64'(b_busy), 64'(!e.rdy));
        check("b_read_data", 64'(b_rdata), e.data);
      end
    end
  end

  initial begin
    a_rst = 1'b1; a_we = 1'b0; a_wreg = '0; a_wdata = '0; a_rreg = '0;
    b_rst = 1'b1; b_we = 1'b0; b_wreg = '0; b_wdata = '0; b_rreg = '0;
    ca = 0; cb = 0;
    for (int k = 0; k < 8; k++)  ma[k] = 32'h0;
    for (int k = 0; k < 16; k++) mb[k] = 16'h0;

    // First reset edge establishes state; expectations start on the second.
    @(posedge clk); #1;
    cycle();

    // Sweep with writes attempted to reg 1 (must be ignored) and reads of reg 1.
    a_rst = 1'b0; a_we = 1'b1; a_wreg = 3'd1; a_wdata = 32'hDEADBEEF; a_rreg = {3'd1, 3'd1};
    b_rst = 1'b0; b_we = 1'b1; b_wreg = 4'd1; b_wdata = 16'hBEEF;     b_rreg = {4'd1, 4'd1, 4'd1};
    repeat (4) cycle();
    a_rst = 1'b1;          // clr_idx == 4 on instance A: restart sweep
    cycle();
    a_rst = 1'b0;
    repeat (12) cycle();
    a_we = 1'b0; b_we = 1'b0;
    cycle();               // both ready, reg 1 reads 0

    // Two writes then a dual-port read.
    a_we = 1'b1; a_wreg = 3'd1; a_wdata = 32'hFFFF1111; cycle();
    a_wreg = 3'd2; a_wdata = 32'hFFFF0000; cycle();
    a_we = 1'b0; a_rreg = {3'd2, 3'd1}; cycle();

    // Same-cycle write/read of reg 5: forwarded on A, old value on B.
    a_we = 1'b1; a_wreg = 3'd5; a_wdata = 32'h12345678; a_rreg = {3'd5, 3'd5};
    b_we = 1'b1; b_wreg = 4'd5; b_wdata = 16'h1234;     b_rreg = {4'd5, 4'd5, 4'd5};
    cycle();
    a_we = 1'b0; b_we = 1'b0; cycle();

    // Register 0: hardwired on A even during the write cycle, ordinary on B.
    a_we = 1'b1; a_wreg = 3'd0; a_wdata = 32'hAAAAAAAA; a_rreg = {3'd0, 3'd0};
    b_we = 1'b1; b_wreg = 4'd0; b_wdata = 16'hAAAA;     b_rreg = {4'd0, 4'd0, 4'd0};
    cycle();
    a_we = 1'b0; b_we = 1'b0; cycle();

    // Top entry of the 16-deep instance on lane 2.
    b_we = 1'b1; b_wreg = 4'd15; b_wdata = 16'hBEEF; cycle();
    b_we = 1'b0; b_rreg = {4'd15, 4'd0, 4'd0}; cycle();

    // Randomised traffic with occasional resets and biased read/write address overlap.
    repeat (300) begin
      a_rst = ($urandom_range(0, 59) == 0);
      b_rst = ($urandom_range(0, 59) == 0);
      a_we = 1'($urandom_range(0, 1)); a_wreg = 3'($urandom); a_wdata = $urandom;
      b_we = 1'($urandom_range(0, 1)); b_wreg = 4'($urandom); b_wdata = 16'($urandom);
      for (int i = 0; i < 2; i++)
        a_rreg[i*3 +: 3] = ($urandom_range(0, 2) == 0) ? a_wreg : 3'($urandom);
      for (int i = 0; i < 3; i++)
        b_rreg[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? b_wreg : 4'($urandom);
      cycle();
    end

    a_rst = 1'b0; b_rst = 1'b0; a_we = 1'b0; b_we = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
